banzai_axil_regs: RTL

AXI4-Lite responder that exposes the banzAI control/status register map to the system bus. Accepts write and read transactions from an external AXI-Lite initiator, holds a bank of read/write control registers driven into the accelerator core, and returns read-only status words sampled from the core. Sits between the ADAM bus fabric and the banzAI datapath.

---
 rtl/banzai_pkg.sv | 38 +++
 rtl/banzai_axil_decode.sv | 28 ++
 rtl/banzai_axil_regs.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/banzai_pkg.sv
// Shared types for the banzAI AXI4-Lite register block: response codes,
// channel FSM states and the byte-strobe merge helper.
package banzai_pkg;

    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } axi_resp_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_ADDR,
        W_HAVE_DATA,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_e;

    function automatic logic [DATA_W-1:0] strb_merge(
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] new_val,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] res;
        res = old_val;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/banzai_axil_decode.sv
// Combinational byte address to register word decode; the low two address
// bits are dropped and anything below BASE_ADDR wraps into the unmapped range.
module banzai_axil_decode #(
    parameter int                ADDR_W    = 32,
    parameter int                NUM_REGS  = 8,
    parameter int                NUM_STAT  = 4,
    parameter int                IDX_W     = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [IDX_W-1:0]  index,
    output logic              is_ctrl,
    output logic              is_stat,
    output logic              is_err
);

    localparam logic [ADDR_W-1:0] CTRL_END = ADDR_W'(NUM_REGS);
    localparam logic [ADDR_W-1:0] STAT_END = ADDR_W'(NUM_REGS + NUM_STAT);

    logic [ADDR_W-1:0] word;

    assign word    = (addr - BASE_ADDR) >> 2;
    assign index   = word[IDX_W-1:0];
    assign is_ctrl = (word < CTRL_END);
    assign is_stat = (word >= CTRL_END) && (word < STAT_END);
    assign is_err  = !is_ctrl && !is_stat;

endmodule

// File: rtl/banzai_axil_regs.sv
// AXI4-Lite responder for the banzAI control/status map: 1-cycle response latency,
// one outstanding transaction per channel. Define BANZAI_AXIL_STRB_EN to honour w_strb.
module banzai_axil_regs #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                NUM_REGS  = 8,
    parameter int                NUM_STAT  = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_W-1:0]                axi_aw_addr,
    input  logic                             axi_aw_valid,
    output logic                             axi_aw_ready,
    input  logic [DATA_W-1:0]                axi_w_data,
    input  logic [3:0]                       axi_w_strb,
    input  logic                             axi_w_valid,
    output logic                             axi_w_ready,
    output logic [1:0]                       axi_b_resp,
    output logic                             axi_b_valid,
    input  logic                             axi_b_ready,
    input  logic [ADDR_W-1:0]                axi_ar_addr,
    input  logic                             axi_ar_valid,
    output logic                             axi_ar_ready,
    output logic [DATA_W-1:0]                axi_r_data,
    output logic [1:0]                       axi_r_resp,
    output logic                             axi_r_valid,
    input  logic                             axi_r_ready,
    output logic [NUM_REGS-1:0][DATA_W-1:0]  reg_o,
    output logic [NUM_REGS-1:0]              reg_wr_o,
    input  logic [NUM_STAT-1:0][DATA_W-1:0]  stat_i
);
    import banzai_pkg::*;

    localparam int IDX_W = $clog2(NUM_REGS + NUM_STAT);

    wr_state_e                      wstate;
    rd_state_e                      rstate;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic [ADDR_W-1:0]              aw_addr_q;
    logic [DATA_W-1:0]              w_data_q;
    logic                           aw_hs, w_hs, ar_hs, commit;
    logic [ADDR_W-1:0]              wr_addr;
    logic [DATA_W-1:0]              wr_data;
    logic [3:0]                     wr_strb;
    logic [IDX_W-1:0]               wr_idx, rd_idx;
    logic                           wr_ctrl, wr_stat, wr_err;
    logic                           rd_ctrl, rd_stat, rd_err;
    logic [DATA_W-1:0]              rd_word;

    assign aw_hs = axi_aw_valid && axi_aw_ready;
    assign w_hs  = axi_w_valid && axi_w_ready;
    assign ar_hs = axi_ar_valid && axi_ar_ready;

    // The second handshake commits using whichever half is live on the bus now.
    assign commit = ((wstate == W_IDLE) && aw_hs && w_hs) ||
                    ((wstate == W_HAVE_ADDR) && w_hs) ||
                    ((wstate == W_HAVE_DATA) && aw_hs);
    assign wr_addr = (wstate == W_HAVE_ADDR) ? aw_addr_q : axi_aw_addr;
    assign wr_data = (wstate == W_HAVE_DATA) ? w_data_q : axi_w_data;

`ifdef BANZAI_AXIL_STRB_EN
    logic [3:0] w_strb_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   w_strb_q <= '0;
        else if (w_hs && (wstate == W_IDLE) && !aw_hs) w_strb_q <= axi_w_strb;
    end
    assign wr_strb = (wstate == W_HAVE_DATA) ? w_strb_q : axi_w_strb;
`else
    logic unused_strb;
    assign unused_strb = ^axi_w_strb;
    assign wr_strb     = 4'hF;
`endif

    banzai_axil_decode #(
        .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .NUM_STAT(NUM_STAT),
        .IDX_W(IDX_W), .BASE_ADDR(BASE_ADDR)
    ) u_wr_dec (
        .addr(wr_addr), .index(wr_idx),
        .is_ctrl(wr_ctrl), .is_stat(wr_stat), .is_err(wr_err)
    );

    banzai_axil_decode #(
        .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .NUM_STAT(NUM_STAT),
        .IDX_W(IDX_W), .BASE_ADDR(BASE_ADDR)
    ) u_rd_dec (
        .addr(axi_ar_addr), .index(rd_idx),
        .is_ctrl(rd_ctrl), .is_stat(rd_stat), .is_err(rd_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate       <= W_IDLE;
            axi_aw_ready <= 1'b0;
            axi_w_ready  <= 1'b0;
            axi_b_valid  <= 1'b0;
            axi_b_resp   <= OKAY;
            aw_addr_q    <= '0;
            w_data_q     <= '0;
            reg_wr_o     <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
        end else begin
            reg_wr_o <= '0;
            case (wstate)
                W_IDLE: begin
                    axi_aw_ready <= 1'b1;
                    axi_w_ready  <= 1'b1;
                    if (aw_hs && !w_hs) begin
                        wstate       <= W_HAVE_ADDR;
                        aw_addr_q    <= axi_aw_addr;
                        axi_aw_ready <= 1'b0;
                    end else if (w_hs && !aw_hs) begin
                        wstate      <= W_HAVE_DATA;
                        w_data_q    <= axi_w_data;
                        axi_w_ready <= 1'b0;
                    end
                end
                W_HAVE_ADDR, W_HAVE_DATA: ;
                W_RESP: begin
                    if (axi_b_ready) begin
                        wstate       <= W_IDLE;
                        axi_b_valid  <= 1'b0;
                        axi_aw_ready <= 1'b1;
                        axi_w_ready  <= 1'b1;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
            if (commit) begin
                wstate       <= W_RESP;
                axi_aw_ready <= 1'b0;
                axi_w_ready  <= 1'b0;
                axi_b_valid  <= 1'b1;
                axi_b_resp   <= (wr_stat || wr_err) ? SLVERR : OKAY;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (wr_ctrl && (wr_idx == IDX_W'(i))) begin
                        regs[i]     <= strb_merge(regs[i], wr_data, wr_strb);
                        reg_wr_o[i] <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (rd_ctrl && (rd_idx == IDX_W'(i))) rd_word = regs[i];
        for (int j = 0; j < NUM_STAT; j++)
            if (rd_stat && (rd_idx == IDX_W'(NUM_REGS + j))) rd_word = stat_i[j];
    end

    // Read data is frozen at the AR handshake, so a same-edge write returns the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstate       <= R_IDLE;
            axi_ar_ready <= 1'b0;
            axi_r_valid  <= 1'b0;
            axi_r_data   <= '0;
            axi_r_resp   <= OKAY;
        end else begin
            case (rstate)
                R_IDLE: begin
                    axi_ar_ready <= 1'b1;
                    if (ar_hs) begin
                        rstate       <= R_RESP;
                        axi_ar_ready <= 1'b0;
                        axi_r_valid  <= 1'b1;
                        axi_r_data   <= rd_word;
                        axi_r_resp   <= rd_err ? SLVERR : OKAY;
                    end
                end
                R_RESP: begin
                    if (axi_r_ready) begin
                        rstate       <= R_IDLE;
                        axi_r_valid  <= 1'b0;
                        axi_ar_ready <= 1'b1;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    assign reg_o = regs;

endmodule
